vvp_accum: RTL and testbench
============================

# vvp_accum

Bit-serial accumulator directly downstream of the vector-vector product (`vvp`) tree. The tree emits one signed partial dot product per data bit-plane. This block combines those planes, MSB-first, into a full-precision signed dot product using Horner shift-and-add. When the data is two's-complement, the MSB plane is given negative weight. One result is emitted per completed word.

## Interface

Parameters:
- `N`, 64: width of the upstream `vvp`. Input width is SW = $clog2(N)+2.
- `MAXP`, 8: maximum data precision in bit-planes (1..MAXP).
- `AW`, SW+MAXP: accumulator and output width (localparam).

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `prec`, input, $clog2(MAXP+1): planes per word. Sampled only on a word's first plane.
- `dsigned`, input, 1: 1 means data is two's-complement. Sampled only on a word's first plane.
- `in_valid`, input, 1: `in_s` carries one bit-plane this cycle.
- `in_first`, input, 1: qualifies `in_valid`; this plane is the MSB plane of a new word.
- `in_s`, input, SW, signed: partial sum from `vvp.S`.
- `out_valid`, output, 1: one-cycle pulse; `out_acc` holds a new result.
- `out_acc`, output, AW, signed: completed dot product. Holds its value until the next `out_valid`.
- `busy`, output, 1: high while a word is partially accumulated (state ACC).
- `err`, output, 1: one-cycle pulse on a protocol violation.

## Operation

General rules:
- No backpressure. The upstream drives one plane per `in_valid` cycle.
- Planes are accepted on rising `clk` when `in_valid`=1.
- Sign-extend `in_s` to AW before all arithmetic. No saturation is needed: |result| ≤ N·(2^MAXP−1) fits in AW.

Precision handling, applied on the first plane:
- `prec`=0 is treated as 1.
- `prec`>MAXP is clamped to MAXP.
- The result is latched into internal `p`. Internal `cnt` holds the planes remaining.

State IDLE (after reset):
- `in_valid`&`in_first`: acc ← `dsigned` ? −sext(in_s) : sext(in_s); latch `p`; cnt ← p−1.
  - If p=1: out_acc ← that value, out_valid pulses next cycle, stay IDLE.
  - Else go to ACC.
- `in_valid`&!`in_first`: plane is discarded; `err` pulses; stay IDLE.
- No `in_valid`: hold.

State ACC:
- `in_valid`&!`in_first`: acc ← (acc<<<1) + sext(in_s); cnt ← cnt−1.
  - If this was the last plane (cnt was 1): out_acc ← new acc, out_valid pulses next cycle, go IDLE.
- `in_valid`&`in_first`: abort the current word. No `out_valid` for it. `err` pulses. Restart exactly as in IDLE with the new plane; `prec` and `dsigned` are re-sampled.
- No `in_valid`: stall; acc and cnt hold. There is no timeout.

Result values:
- Unsigned: Σ S_j·2^j.
- Signed: −S_{p−1}·2^{p−1} + Σ_{j<p−1} S_j·2^j.

Outputs:
- `busy` = (state==ACC).

Reset values:
- state IDLE; acc, cnt, out_acc = 0; out_valid, busy, err = 0.

## Timing

Latency and throughput:
- `out_valid` and the new `out_acc` appear in the cycle after the edge that accepts the last plane (1-cycle registered latency).
- Throughput is one word per p cycles. Back-to-back words need no bubble: the next word's first plane may be accepted in the same cycle `out_valid` is high.

Reset behaviour:
- `rst` has priority over all inputs.
- Reset in the middle of a word discards the word; no `out_valid` follows.
- A plane presented during the `rst` cycle is ignored.

Other rules:
- `err` and `out_valid` are never high in the same cycle, except when a p=1 word completes in the same edge as an abort. In that case both pulse.
- `prec` and `dsigned` changes in the middle of a word have no effect.
- `out_acc` is unchanged when `err` pulses.

## Test plan

N=64, MAXP=8 throughout.

1. Unsigned, prec=4, planes 3, −1, 0, 5 on consecutive cycles → one cycle after the 4th plane: out_valid=1, out_acc=25. busy is high for cycles 2–4.
2. Signed, same planes → out_acc=−23. Signed, prec=8, all planes 64 → −64. Unsigned, prec=8, all planes 64 → 16320.
3. Stall: planes of case 1 with `in_valid` low 0, 2, 1 cycles between them → out_acc=25, one cycle after the last accepted plane. acc stays frozen during the gaps.
4. Abort: 2 planes of one word, then `in_first` with a new prec=2 unsigned word 7, 1 → err pulses once; a single out_valid follows with out_acc=15. Also: `in_valid` without `in_first` in IDLE → err pulse, no out_valid.
5. Reset after 2 planes of a prec=4 word → no out_valid, all outputs 0. A following word gives the correct result.
6. Back-to-back prec=1 words 5, −3, 64 (unsigned) → out_valid high 3 consecutive cycles, out_acc 5, −3, 64. Also: prec=0 behaves as 1; prec=12 behaves as 8.

Source files
------------

// File: rtl/vvp_accum.sv
// vvp_accum: bit-serial Horner accumulator for the vvp tree.
// Combines one signed partial dot product per data bit-plane, MSB plane first,
// into a full-precision signed result. For two's-complement data the MSB plane
// carries negative weight, which is realised by negating the first plane.
module vvp_accum #(
  parameter  int N    = 64,
  parameter  int MAXP = 8,
  localparam int SW   = $clog2(N) + 2,
  localparam int AW   = SW + MAXP,
  localparam int PW   = $clog2(MAXP + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        prec,
  input  logic                 dsigned,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic signed [SW-1:0] in_s,
  output logic                 out_valid,
  output logic signed [AW-1:0] out_acc,
  output logic                 busy,
  output logic                 err
);

  localparam logic [PW-1:0] MAXP_P = PW'(MAXP);
  localparam logic [PW-1:0] ONE_P  = PW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic        [PW-1:0]  cnt_q, cnt_d;
  logic        [PW-1:0]  p_q, p_d;
  logic signed [AW-1:0]  out_acc_q, out_acc_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;

  // Working values derived from the current input plane.
  logic signed [AW-1:0]  in_ext;
  logic signed [AW-1:0]  first_val;
  logic signed [AW-1:0]  horner_val;
  logic        [PW-1:0]  p_eff;

  // Sign-extend the plane; the first plane of signed data is negated, later planes are Horner-added.
  always_comb begin
    in_ext     = {{(AW-SW){in_s[SW-1]}}, in_s};
    first_val  = dsigned ? -in_ext : in_ext;
    horner_val = (acc_q <<< 1) + in_ext;
  end

  // Legalise the requested precision: 0 acts as 1, anything above MAXP is clamped.
  always_comb begin
    p_eff = prec;
    if (prec == '0) begin
      p_eff = ONE_P;
    end else if (prec > MAXP_P) begin
      p_eff = MAXP_P;
    end
  end

  // Next-state and datapath control for the IDLE/ACC word sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_acc_d   = out_acc_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;

    if (in_valid) begin
      if (in_first) begin
        // A first plane while a word is open aborts that word; it is never reported.
        if (state_q == ACC) begin
          err_d = 1'b1;
        end
        // Start a new word (identical from IDLE or after an abort).
        acc_d = first_val;
        p_d   = p_eff;
        cnt_d = p_eff - ONE_P;
        if (p_eff == ONE_P) begin
          // Single-plane word completes immediately.
          out_acc_d   = first_val;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = ACC;
        end
      end else begin
        if (state_q == ACC) begin
          acc_d = horner_val;
          cnt_d = cnt_q - ONE_P;
          if (cnt_q == ONE_P) begin
            // Last plane of the word: publish and return to IDLE.
            out_acc_d   = horner_val;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          // Continuation plane with no open word: drop it and flag the protocol error.
          err_d = 1'b1;
        end
      end
    end
    // Without in_valid everything holds: a stall in ACC freezes acc and cnt indefinitely.
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_acc_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_acc_q   <= out_acc_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign err       = err_q;
  assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_vvp_accum.sv
// Directed, table-driven bench for vvp_accum (N=64, MAXP=8 -> SW=8, AW=16).
module tb_vvp_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         prec;
  logic               dsigned;
  logic               in_valid;
  logic               in_first;
  logic signed [7:0]  in_s;
  logic               out_valid;
  logic signed [15:0] out_acc;
  logic               busy;
  logic               err;

  int tests_run = 0;
  int tests_failed = 0;

  vvp_accum #(.N(64), .MAXP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .prec     (prec),
    .dsigned  (dsigned),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_s     (in_s),
    .out_valid(out_valid),
    .out_acc  (out_acc),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      prec;
    logic            ds;
    int              n;      // planes actually consumed (effective precision)
    logic [7:0][7:0] pl;     // pl[i] = plane i, MSB plane first
    int              exp;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [3:0] pr, input logic ds, input int n,
                              input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int p6, input int p7,
                              input int exp);
    vec_t v;
    v.prec = pr; v.ds = ds; v.n = n; v.exp = exp;
    v.pl[0] = p0[7:0]; v.pl[1] = p1[7:0]; v.pl[2] = p2[7:0]; v.pl[3] = p3[7:0];
    v.pl[4] = p4[7:0]; v.pl[5] = p5[7:0]; v.pl[6] = p6[7:0]; v.pl[7] = p7[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input integer act, input integer exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one input cycle, let the edge happen, then sample 1 time unit later.
  task automatic drive(input logic v, input logic f, input int s,
                       input logic [3:0] pr, input logic ds);
    logic [31:0] sv;
    sv       = s;
    in_valid = v;
    in_first = f;
    in_s     = sv[7:0];
    prec     = pr;
    dsigned  = ds;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 0, 4'd0, 1'b0);
  endtask

  integer last_acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_s = '0; prec = '0; dsigned = 1'b0;

    vecs[0] = mk(4'd4,  1'b0, 4,   3,  -1,   0,   5,  0,  0,  0,  0,    25);
    vecs[1] = mk(4'd4,  1'b1, 4,   3,  -1,   0,   5,  0,  0,  0,  0,   -23);
    vecs[2] = mk(4'd8,  1'b1, 8,  64,  64,  64,  64, 64, 64, 64, 64,   -64);
    vecs[3] = mk(4'd8,  1'b0, 8,  64,  64,  64,  64, 64, 64, 64, 64, 16320);
    vecs[4] = mk(4'd0,  1'b0, 1,   5,   0,   0,   0,  0,  0,  0,  0,     5);
    vecs[5] = mk(4'd1,  1'b1, 1,   5,   0,   0,   0,  0,  0,  0,  0,    -5);
    vecs[6] = mk(4'd12, 1'b0, 8,   1,   1,   1,   1,  1,  1,  1,  1,   255);
    vecs[7] = mk(4'd2,  1'b1, 2,   1,   1,   0,   0,  0,  0,  0,  0,    -1);
    vecs[8] = mk(4'd3,  1'b0, 3, 127,-128, 127,   0,  0,  0,  0,  0,   379);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_acc",   out_acc,   0);
    chk("reset_busy",      busy,      0);
    chk("reset_err",       err,       0);
    rst = 1'b0;
    idle_cycle();

    // Table-driven words
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < vecs[k].n; i++) begin
        drive(1'b1, (i == 0), int'($signed(vecs[k].pl[i])), vecs[k].prec, vecs[k].ds);
        if (i < vecs[k].n - 1) begin
          chk($sformatf("v%0d_p%0d_busy", k, i), busy, 1);
          chk($sformatf("v%0d_p%0d_noval", k, i), out_valid, 0);
        end else begin
          chk($sformatf("v%0d_valid", k), out_valid, 1);
          chk($sformatf("v%0d_acc", k), out_acc, vecs[k].exp);
          chk($sformatf("v%0d_idle", k), busy, 0);
          chk($sformatf("v%0d_err", k), err, 0);
        end
      end
      idle_cycle();
      chk($sformatf("v%0d_pulse", k), out_valid, 0);
      chk($sformatf("v%0d_hold", k), out_acc, vecs[k].exp);
      $display("[TB] vector %0d prec=%0d signed=%0d -> out_acc=%0d (expected %0d)",
               k, vecs[k].prec, vecs[k].ds, out_acc, vecs[k].exp);
    end
    last_acc = 379;

    // Stall: gaps of 0, 2, 1 idle cycles between planes; prec change mid-word ignored
    drive(1'b1, 1'b1, 3, 4'd4, 1'b0);
    drive(1'b1, 1'b0, -1, 4'd2, 1'b1);
    idle_cycle(); idle_cycle();
    chk("stall_busy", busy, 1);
    chk("stall_noval", out_valid, 0);
    drive(1'b1, 1'b0, 0, 4'd1, 1'b1);
    idle_cycle();
    chk("stall_busy2", busy, 1);
    drive(1'b1, 1'b0, 5, 4'd4, 1'b0);
    chk("stall_valid", out_valid, 1);
    chk("stall_acc", out_acc, 25);
    $display("[TB] stall word -> out_acc=%0d", out_acc);
    idle_cycle();
    last_acc = 25;

    // Abort: two planes, then a new prec=2 unsigned word 7,1
    drive(1'b1, 1'b1, 3, 4'd4, 1'b0);
    drive(1'b1, 1'b0, -1, 4'd4, 1'b0);
    drive(1'b1, 1'b1, 7, 4'd2, 1'b0);
    chk("abort_err", err, 1);
    chk("abort_noval", out_valid, 0);
    chk("abort_acc_held", out_acc, last_acc);
    chk("abort_busy", busy, 1);
    drive(1'b1, 1'b0, 1, 4'd2, 1'b0);
    chk("abort_err_clr", err, 0);
    chk("abort_valid", out_valid, 1);
    chk("abort_acc", out_acc, 15);
    $display("[TB] abort then new word -> err seen, out_acc=%0d", out_acc);
    idle_cycle();
    last_acc = 15;

    // Stray continuation plane in IDLE
    drive(1'b1, 1'b0, 9, 4'd4, 1'b0);
    chk("stray_err", err, 1);
    chk("stray_noval", out_valid, 0);
    chk("stray_busy", busy, 0);
    chk("stray_acc", out_acc, last_acc);
    idle_cycle();
    chk("stray_err_clr", err, 0);
    $display("[TB] stray plane in IDLE -> err pulse");

    // Abort coinciding with a p=1 word: both pulses together
    drive(1'b1, 1'b1, 3, 4'd4, 1'b0);
    drive(1'b1, 1'b1, 9, 4'd1, 1'b0);
    chk("coinc_err", err, 1);
    chk("coinc_valid", out_valid, 1);
    chk("coinc_acc", out_acc, 9);
    chk("coinc_busy", busy, 0);
    $display("[TB] abort + p=1 word -> err=%0d out_valid=%0d out_acc=%0d", err, out_valid, out_acc);
    idle_cycle();

    // Reset mid-word, with a plane presented during the reset cycle
    drive(1'b1, 1'b1, 3, 4'd4, 1'b0);
    drive(1'b1, 1'b0, -1, 4'd4, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 7, 4'd1, 1'b0);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    idle_cycle();
    chk("rst_noval", out_valid, 0);
    drive(1'b1, 1'b1, 3, 4'd4, 1'b0);
    drive(1'b1, 1'b0, -1, 4'd4, 1'b0);
    drive(1'b1, 1'b0, 0, 4'd4, 1'b0);
    drive(1'b1, 1'b0, 5, 4'd4, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_acc", out_acc, 25);
    $display("[TB] word after reset -> out_acc=%0d", out_acc);

    // Back-to-back prec=1 words with no bubble (first one shares the cycle with the previous out_valid)
    drive(1'b1, 1'b1, 5, 4'd1, 1'b0);
    chk("b2b0_valid", out_valid, 1);
    chk("b2b0_acc", out_acc, 5);
    drive(1'b1, 1'b1, -3, 4'd1, 1'b0);
    chk("b2b1_valid", out_valid, 1);
    chk("b2b1_acc", out_acc, -3);
    chk("b2b1_err", err, 0);
    drive(1'b1, 1'b1, 64, 4'd1, 1'b0);
    chk("b2b2_valid", out_valid, 1);
    chk("b2b2_acc", out_acc, 64);
    idle_cycle();
    chk("b2b_end", out_valid, 0);
    $display("[TB] back-to-back p=1 words -> last out_acc=%0d", out_acc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
